// File: rtl/sign_compress_pkg.sv
// Shared definitions for the sign_compress slice: FSM encoding and cls width helper.
package sign_compress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF   = 32;
  localparam int NARROW_W_DEF = 16;

  function automatic int cls_width(input int data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/sign_compress_sat_narrow.sv
// Narrows a word to NARROW_W bits, saturating toward the sign when it does not fit.
module sat_narrow #(
  parameter int DATA_W   = 32,
  parameter int NARROW_W = 16
) (
  input  logic [DATA_W-1:0]   orig,
  input  logic                fits,
  output logic [NARROW_W-1:0] narrow
);

  logic [NARROW_W-1:0] sat_pos;
  logic [NARROW_W-1:0] sat_neg;

  assign sat_pos = {1'b0, {(NARROW_W-1){1'b1}}};
  assign sat_neg = {1'b1, {(NARROW_W-1){1'b0}}};

  always_comb begin
    if (fits) narrow = orig[NARROW_W-1:0];
    else      narrow = orig[DATA_W-1] ? sat_neg : sat_pos;
  end

endmodule

// File: rtl/sign_compress.sv
// Iterative count-leading-sign-bits unit: one shift per cycle, then normalised,
// saturated-narrow and fits results held until the consumer takes them.
//   state   | meaning
//   IDLE    | waiting for in_valid, in_ready high
//   SCAN    | shifting out redundant sign bits, one per cycle
//   DONE    | results valid, waiting for out_ready
module sign_compress
  import sign_compress_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NARROW_W = NARROW_W_DEF,
  localparam int CLS_W   = cls_width(DATA_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CLS_W-1:0]    cls,
  output logic [DATA_W-1:0]   norm,
  output logic                fits,
  output logic [NARROW_W-1:0] narrow
);

  localparam logic [CLS_W-1:0] CNT_MAX  = CLS_W'(DATA_W-1);
  localparam logic [CLS_W-1:0] FITS_MIN = CLS_W'(DATA_W-NARROW_W);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   orig_q, orig_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CLS_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [CLS_W-1:0]    cls_q, cls_d;
  logic [DATA_W-1:0]   norm_q, norm_d;
  logic                fits_q, fits_d;
  logic [NARROW_W-1:0] narrow_q, narrow_d;

  logic                fits_now;
  logic [NARROW_W-1:0] narrow_sat;

  // Every shift so far removed a redundant sign bit, so cnt alone decides fit.
  assign fits_now = (cnt_q >= FITS_MIN);

  sat_narrow #(
    .DATA_W  (DATA_W),
    .NARROW_W(NARROW_W)
  ) u_sat_narrow (
    .orig  (orig_q),
    .fits  (fits_now),
    .narrow(narrow_sat)
  );

  always_comb begin
    state_d     = state_q;
    orig_d      = orig_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    cls_d       = cls_q;
    norm_d      = norm_q;
    fits_d      = fits_q;
    narrow_d    = narrow_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          orig_d  = in_data;
          shreg_d = in_data;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if ((shreg_q[DATA_W-1] == shreg_q[DATA_W-2]) && (cnt_q < CNT_MAX)) begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CLS_W'(1);
        end else begin
          cls_d       = cnt_q;
          norm_d      = shreg_q;
          fits_d      = fits_now;
          narrow_d    = narrow_sat;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      orig_q      <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      cls_q       <= '0;
      norm_q      <= '0;
      fits_q      <= 1'b0;
      narrow_q    <= '0;
    end else begin
      state_q     <= state_d;
      orig_q      <= orig_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      cls_q       <= cls_d;
      norm_q      <= norm_d;
      fits_q      <= fits_d;
      narrow_q    <= narrow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign cls       = cls_q;
  assign norm      = norm_q;
  assign fits      = fits_q;
  assign narrow    = narrow_q;

endmodule
